// File: rtl/i2c_slave_responder_pkg.sv
// Shared types, register map and helpers for the I2C slave responder.
package i2c_slave_responder_pkg;

    localparam int unsigned CFG_AW       = 16;
    localparam int unsigned CFG_DW       = 32;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned TX_W         = 64;
    localparam int unsigned MAX_RD_BYTES = 8;

    // Peripheral windows on the config bus; each block owns a 16-byte window.
    localparam logic [CFG_AW-1:0] I2C_BASE_ADDR  = 16'h0100;
    localparam logic [CFG_AW-1:0] UART_BASE_ADDR = 16'h0200;
    localparam logic [CFG_AW-1:0] I2CS_BASE_ADDR = 16'h0300;

    localparam logic [CFG_AW-1:0] I2CS_CTRL_OFS = 16'h0000;
    localparam logic [CFG_AW-1:0] I2CS_LEN_OFS  = 16'h0004;
    localparam logic [CFG_AW-1:0] I2CS_TX0_OFS  = 16'h0008;
    localparam logic [CFG_AW-1:0] I2CS_TX1_OFS  = 16'h000C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2cs_state_t;

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_LEN,
        REG_TX0,
        REG_TX1
    } i2cs_reg_t;

    typedef struct packed {
        logic              enable;
        logic [ADDR_W-1:0] own_addr;
        logic [CNT_W-1:0]  len;
        logic [TX_W-1:0]   tx_data;
    } i2cs_cfg_t;

    function automatic logic cfg_hit(input logic [CFG_AW-1:0] addr);
        return (addr[CFG_AW-1:4] == I2CS_BASE_ADDR[CFG_AW-1:4]) && (addr[1:0] == 2'b00);
    endfunction

    function automatic i2cs_reg_t cfg_reg_sel(input logic [CFG_AW-1:0] addr);
        return i2cs_reg_t'(addr[3:2]);
    endfunction

    // LEN values above the shifter depth behave as a full shifter.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len > CNT_W'(MAX_RD_BYTES)) ? CNT_W'(MAX_RD_BYTES) : len;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with registered SCL edge and START/STOP event pulses.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_rise_q;
    logic                   scl_fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Flops reset high so a reset looks like an idle bus, never a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            scl_rise_q <= scl_s & ~scl_hist_q;
            scl_fall_q <= ~scl_s & scl_hist_q;
            start_q    <= scl_s & scl_hist_q & sda_hist_q & ~sda_s;
            stop_q     <= scl_s & scl_hist_q & ~sda_hist_q & sda_s;
        end
    end

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave: config registers, protocol FSM, write capture and read shifter.
module i2c_slave_responder
    import i2c_slave_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLV_ADDR_RST = 7'h50,
    parameter int unsigned       SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CFG_AW-1:0] cfg_addr,
    input  logic [CFG_DW-1:0] cfg_wdata,
    input  logic              cfg_write,
    output logic [BYTE_W-1:0] rx_data_out,
    output logic              rx_valid_out,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              busy
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_in),
        .sda_i     (sda_in),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_det),
        .stop_o    (stop_det)
    );

    // Config register file.
    i2cs_cfg_t cfg_q, cfg_d;

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_write && cfg_hit(cfg_addr)) begin
            unique case (cfg_reg_sel(cfg_addr))
                REG_CTRL: begin
                    cfg_d.own_addr = cfg_wdata[ADDR_W-1:0];
                    cfg_d.enable   = cfg_wdata[8];
                end
                REG_LEN:  cfg_d.len               = clamp_len(cfg_wdata[CNT_W-1:0]);
                REG_TX0:  cfg_d.tx_data[31:0]     = cfg_wdata;
                REG_TX1:  cfg_d.tx_data[TX_W-1:32] = cfg_wdata;
                default:  cfg_d = cfg_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q.enable   <= 1'b0;
            cfg_q.own_addr <= SLV_ADDR_RST;
            cfg_q.len      <= '0;
            cfg_q.tx_data  <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    i2cs_state_t       state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [CNT_W-1:0]  byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]  len_snap_q, len_snap_d;
    logic [TX_W-1:0]   tx_shift_q, tx_shift_d;
    logic              sda_oe_q, sda_oe_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;

    logic [2:0]        bit_sel_c;
    logic              drive_low_c;
    logic              addr_match_c;

    // Current read bit: byte in tx_shift_q[7:0], MSB first; bytes past LEN stay released.
    assign bit_sel_c    = ~bit_cnt_q[2:0];
    assign drive_low_c  = (byte_idx_q < len_snap_q) && !tx_shift_q[bit_sel_c];
    assign addr_match_c = cfg_q.enable && (shift_q[BYTE_W-1:1] == cfg_q.own_addr);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        byte_idx_d = byte_idx_q;
        len_snap_d = len_snap_q;
        tx_shift_d = tx_shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise && (bit_cnt_q < CNT_W'(BYTE_W))) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && (bit_cnt_q == CNT_W'(BYTE_W))) begin
                        bit_cnt_d = '0;
                        if (addr_match_c) begin
                            state_d    = ST_ADDR_ACK;
                            sda_oe_d   = 1'b1;
                            rw_d       = shift_q[0];
                            byte_idx_d = '0;
                            len_snap_d = cfg_q.len;
                            tx_shift_d = cfg_q.tx_data;
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = ST_RD_BYTE;
                            sda_oe_d = drive_low_c;
                        end else begin
                            state_d  = ST_WR_BYTE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise && (bit_cnt_q < CNT_W'(BYTE_W))) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                            rx_data_d  = {shift_q[BYTE_W-2:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && (bit_cnt_q == CNT_W'(BYTE_W))) begin
                        state_d   = ST_WR_ACK;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WR_BYTE;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise && (bit_cnt_q < CNT_W'(BYTE_W))) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt_q == CNT_W'(BYTE_W)) begin
                            state_d    = ST_RD_ACK;
                            bit_cnt_d  = '0;
                            sda_oe_d   = 1'b0;
                            tx_shift_d = {BYTE_W'(0), tx_shift_q[TX_W-1:BYTE_W]};
                            if (byte_idx_q < CNT_W'(MAX_RD_BYTES)) begin
                                byte_idx_d = byte_idx_q + CNT_W'(1);
                            end
                        end else begin
                            sda_oe_d = drive_low_c;
                        end
                    end
                end
                ST_RD_ACK: begin
                    // Master's ACK bit is sampled here; the next byte starts on the following fall.
                    if (scl_rise) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        state_d   = sda_s ? ST_IGNORE : ST_RD_BYTE;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_IGNORE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            byte_idx_q <= '0;
            len_snap_q <= '0;
            tx_shift_q <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            byte_idx_q <= byte_idx_d;
            len_snap_q <= len_snap_d;
            tx_shift_q <= tx_shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data_out  = rx_data_q;
    assign rx_valid_out = rx_valid_q;
    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Scoreboard bench for i2c_slave_responder driven by a bit-level I2C master model.
module tb_i2c_slave_responder;
    import i2c_slave_responder_pkg::*;

    localparam int unsigned Q = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_write;
    logic [7:0]  rx_data_out;
    logic        rx_valid_out;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic        busy;

    // Open-drain bus: either side can pull SDA low.
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_responder #(
        .SLV_ADDR_RST(7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_write   (cfg_write),
        .rx_data_out (rx_data_out),
        .rx_valid_out(rx_valid_out),
        .scl_in      (scl_m),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .busy        (busy)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         oe_cnt = 0;
    int         busy_drop = 0;
    bit         busy_watch = 1'b0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] obs_rd_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expected responses whenever the DUT or master presents data.
    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (busy_watch && !busy) busy_drop++;
        if (rx_valid_out) begin
            if (exp_rx_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rx_unexpected: got 0x%0h expected no byte", rx_data_out);
            end else begin
                check("rx_data", 32'(rx_data_out), 32'(exp_rx_q.pop_front()));
            end
        end
        if (obs_rd_q.size() != 0) begin
            logic [7:0] got;
            got = obs_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%0h expected no byte", got);
            end else begin
                check("rd_data", 32'(got), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [15:0] ofs, input logic [31:0] data);
        @(negedge clk);
        cfg_addr  = I2CS_BASE_ADDR + ofs;
        cfg_wdata = data;
        cfg_write = 1'b1;
        @(negedge clk);
        cfg_write = 1'b0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b1; clks(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    clks(Q);
        scl_m = 1'b1; clks(2 * Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        b = sda_line; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte();
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        obs_rd_q.push_back(d);
    endtask

    initial begin
        logic ack;
        logic b;
        scl_m = 1'b1; sda_m = 1'b1;
        cfg_addr = '0; cfg_wdata = '0; cfg_write = 1'b0;
        rst = 1'b1;
        clks(4);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rx_valid", 32'(rx_valid_out), 0);
        check("rst_rx_data", 32'(rx_data_out), 0);

        // Reset leaves enable clear: own address must be NACKed.
        bus_start(); write_byte(8'hA0, ack); check("rst_disabled_nack", 32'(ack), 1); bus_stop();

        // Write two bytes. CTRL: own address 0x50 in [6:0], enable in [8].
        cfg_wr(I2CS_CTRL_OFS, 32'h0000_0150);
        exp_rx_q.push_back(8'h12); exp_rx_q.push_back(8'h34);
        bus_start();
        write_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 0);
        write_byte(8'h12, ack); check("wr_d0_ack", 32'(ack), 0);
        write_byte(8'h34, ack); check("wr_d1_ack", 32'(ack), 0);
        bus_stop(); clks(8);
        check("wr_busy_after_stop", 32'(busy), 0);
        check("rx_data_hold", 32'(rx_data_out), 32'h34);

        // Read four bytes with LEN=3; the fourth reads as idle bus.
        cfg_wr(I2CS_LEN_OFS, 32'd3);
        cfg_wr(I2CS_TX0_OFS, 32'h00CC_BBAA);
        cfg_wr(I2CS_TX1_OFS, 32'h0);
        exp_rd_q.push_back(8'hAA); exp_rd_q.push_back(8'hBB);
        exp_rd_q.push_back(8'hCC); exp_rd_q.push_back(8'hFF);
        bus_start();
        write_byte(8'hA1, ack); check("rd_addr_ack", 32'(ack), 0);
        for (int i = 0; i < 4; i++) begin
            read_byte();
            write_bit((i == 3) ? 1'b1 : 1'b0);
        end
        clks(6);
        check("rd_oe_after_nack", 32'(sda_oe), 0);
        check("rd_busy_after_nack", 32'(busy), 0);
        bus_stop();

        // Foreign address 0x51: no ACK, SDA never driven.
        oe_cnt = 0;
        bus_start();
        write_byte(8'hA2, ack); check("foreign_addr_nack", 32'(ack), 1);
        write_byte(8'h99, ack); check("foreign_data_nack", 32'(ack), 1);
        bus_stop(); clks(4);
        check("foreign_oe_cycles", 32'(oe_cnt), 0);

        // Write, repeated START, read one byte; busy stays high across the restart.
        exp_rx_q.push_back(8'h05); exp_rd_q.push_back(8'hAA);
        busy_drop = 0;
        bus_start();
        busy_watch = 1'b1;
        write_byte(8'hA0, ack); check("rs_wr_addr_ack", 32'(ack), 0);
        write_byte(8'h05, ack); check("rs_wr_d_ack", 32'(ack), 0);
        bus_start();
        write_byte(8'hA1, ack); check("rs_rd_addr_ack", 32'(ack), 0);
        read_byte();
        busy_watch = 1'b0;
        write_bit(1'b1);
        bus_stop();
        check("rs_busy_drops", 32'(busy_drop), 0);
        check("rs_rx_data", 32'(rx_data_out), 32'h05);

        // LEN=8 full shifter then saturation; a mid-transfer TX write must not leak in.
        cfg_wr(I2CS_LEN_OFS, 32'd8);
        cfg_wr(I2CS_TX0_OFS, 32'h4433_2211);
        cfg_wr(I2CS_TX1_OFS, 32'h8877_6655);
        for (int i = 1; i <= 8; i++) exp_rd_q.push_back(8'((i << 4) | i));
        exp_rd_q.push_back(8'hFF); exp_rd_q.push_back(8'hFF);
        bus_start();
        write_byte(8'hA1, ack); check("sat_addr_ack", 32'(ack), 0);
        for (int i = 0; i < 10; i++) begin
            read_byte();
            if (i == 0) cfg_wr(I2CS_TX0_OFS, 32'h0);
            write_bit((i == 9) ? 1'b1 : 1'b0);
        end
        bus_stop();

        // Matching address with enable clear: NACK and silence.
        cfg_wr(I2CS_CTRL_OFS, 32'h0000_0050);
        oe_cnt = 0;
        bus_start();
        write_byte(8'hA0, ack); check("dis_addr_nack", 32'(ack), 1);
        write_byte(8'h55, ack); check("dis_data_nack", 32'(ack), 1);
        bus_stop(); clks(4);
        check("dis_oe_cycles", 32'(oe_cnt), 0);

        // Reset during the third bit of a read byte of 0x00.
        cfg_wr(I2CS_CTRL_OFS, 32'h0000_0150);
        cfg_wr(I2CS_LEN_OFS, 32'd1);
        cfg_wr(I2CS_TX0_OFS, 32'h0);
        bus_start();
        write_byte(8'hA1, ack); check("rst_rd_addr_ack", 32'(ack), 0);
        read_bit(b); check("rst_rd_bit7", 32'(b), 0);
        read_bit(b); check("rst_rd_bit6", 32'(b), 0);
        @(negedge clk);
        check("oe_before_rst", 32'(sda_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        check("oe_after_rst", 32'(sda_oe), 0);
        check("busy_after_rst", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(2 * Q);
        check("rx_data_after_rst", 32'(rx_data_out), 0);
        check("oe_idle_after_rst", 32'(sda_oe), 0);
        cfg_wr(I2CS_CTRL_OFS, 32'h0000_0150);
        exp_rx_q.push_back(8'h77);
        bus_start();
        write_byte(8'hA0, ack); check("post_rst_addr_ack", 32'(ack), 0);
        write_byte(8'h77, ack); check("post_rst_d_ack", 32'(ack), 0);
        bus_stop();

        clks(20);
        check("rx_pending", 32'(exp_rx_q.size()), 0);
        check("rd_pending", 32'(exp_rd_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
